// File: rtl/sigma_acc.sv
// sigma_acc: signed-magnitude multi-lane accumulator.
// Accepts BEATS = ceil(TERMS/LANES) input beats, sums each beat lane by lane,
// accumulates the beat sums with clamping, and presents the total with a
// saturation flag until the downstream side takes it.
module sigma_acc #(
  parameter int N     = 16,
  parameter int F     = 8,
  parameter int LANES = 4,
  parameter int TERMS = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0][N-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N-1:0]              out_data,
  output logic                      out_sat
);

  localparam int          BEATS      = (TERMS + LANES - 1) / LANES;
  localparam int unsigned LAST_LANES = TERMS - (BEATS - 1) * LANES;
  localparam int          CW         = $clog2(BEATS + 1);

  // Elaboration-time legality checks on the configuration.
  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("sigma_acc: LANES out of range");
  end
  if (TERMS < 1 || TERMS > 1024) begin : g_bad_terms
    $error("sigma_acc: TERMS out of range");
  end
  if (F < 0 || F > N - 1) begin : g_bad_frac
    $error("sigma_acc: F out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  state_t          r_state, w_next;
  logic [N-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_sat;

  logic            w_accept;
  logic            w_last;
  logic [N-1:0]    w_beat_sum;
  logic            w_beat_sat;
  logic [N:0]      w_acc_sum;
  logic [N:0]      w_tmp;
  logic [N-1:0]    w_op;

  // Signed-magnitude add with clamping; returns {saturated, result}.
  // Negative zero on either operand is treated as +0, and a zero result is +0.
  function automatic logic [N:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic          sa, sb, sr, so;
    logic [N-2:0]  ma, mb, mr;
    logic [N-1:0]  s;
    ma = a[N-2:0];
    mb = b[N-2:0];
    sa = a[N-1] & (ma != '0);
    sb = b[N-1] & (mb != '0);
    so = 1'b0;
    if (sa == sb) begin
      s  = {1'b0, ma} + {1'b0, mb};
      sr = sa;
      if (s[N-1]) begin
        mr = '1;
        so = 1'b1;
      end else begin
        mr = s[N-2:0];
      end
    end else if (ma >= mb) begin
      mr = ma - mb;
      sr = sa;
    end else begin
      mr = mb - ma;
      sr = sb;
    end
    if (mr == '0) sr = 1'b0;
    return {so, sr, mr};
  endfunction

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_state == S_IDLE) ? (BEATS == 1) : (r_cnt == CW'(BEATS - 1));

  // Beat sum ((lane0+lane1)+lane2)+..., with unused final-beat lanes forced to +0.
  always_comb begin
    w_beat_sum = in_data[0];
    w_beat_sat = 1'b0;
    w_tmp      = '0;
    w_op       = '0;
    for (int unsigned i = 1; i < LANES; i++) begin
      w_op = (w_last && i >= LAST_LANES) ? '0 : in_data[i];
      w_tmp = sm_add(w_beat_sum, w_op);
      w_beat_sum = w_tmp[N-1:0];
      w_beat_sat = w_beat_sat | w_tmp[N];
    end
    w_acc_sum = sm_add(r_acc, w_beat_sum);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_sat   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_next = (BEATS == 1) ? S_OUT : S_ACC;
      end
      S_ACC: begin
        in_ready = 1'b1;
        if (w_accept && w_last) w_next = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_data  = r_acc;
        out_sat   = r_sat;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Accumulator, beat counter and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        r_acc <= w_beat_sum;
        r_cnt <= CW'(1);
        r_sat <= w_beat_sat;
      end else begin
        r_acc <= w_acc_sum[N-1:0];
        r_cnt <= r_cnt + CW'(1);
        r_sat <= r_sat | w_beat_sat | w_acc_sum[N];
      end
    end
  end

endmodule

// File: tb/tb_sigma_acc.sv
// Directed testbench for sigma_acc with N=16, F=8, LANES=4, TERMS=7 (2 beats).
module tb_sigma_acc;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0][15:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic              out_sat;

  int errors;
  int checks;

  sigma_acc #(.N(16), .F(8), .LANES(4), .TERMS(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0][15:0] mk(input logic [15:0] l0, input logic [15:0] l1,
                                           input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Offer one beat; waits (bounded) for in_ready; samples #1 after the accept edge.
  task automatic send_beat(input logic [3:0][15:0] d, output logic ok);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    ok = in_ready;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Two-beat sum; returns out_valid after beat 1, and outputs right after beat 2.
  task automatic do_sum(input logic [3:0][15:0] b0, input logic [3:0][15:0] b1,
                        output logic v_mid, output logic v, output logic [15:0] d,
                        output logic s, output logic ok);
    logic ok0, ok1;
    send_beat(b0, ok0);
    v_mid = out_valid;
    send_beat(b1, ok1);
    v  = out_valid;
    d  = out_data;
    s  = out_sat;
    ok = ok0 & ok1;
  endtask

  // Take the result and return the post-handshake out_valid / out_data.
  task automatic take(output logic v, output logic [15:0] d);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    v = out_valid;
    d = out_data;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h sat=%b required 0 0000 0", out_valid, out_data, out_sat);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic;
    logic vm, v, s, ok, v2;
    logic [15:0] d, d2;
    do_sum(mk(16'h0100, 16'h0100, 16'h0100, 16'h0100),
           mk(16'h0100, 16'h0100, 16'h0100, 16'h7FFF), vm, v, d, s, ok);
    checks++;
    if (vm !== 1'b0 || ok !== 1'b1) begin
      errors++;
      $display("FAIL basic_mid: out_valid=%b ready_ok=%b required 0 1", vm, ok);
    end
    checks++;
    if (v !== 1'b1 || d !== 16'h0700 || s !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: valid=%b data=%h sat=%b required 1 0700 0", v, d, s);
    end
    take(v2, d2);
    checks++;
    if (v2 !== 1'b0 || d2 !== 16'h0000) begin
      errors++;
      $display("FAIL basic_after_take: valid=%b data=%h required 0 0000", v2, d2);
    end
  endtask

  task automatic test_neg_zero;
    logic vm, v, s, ok, v2;
    logic [15:0] d, d2;
    do_sum(mk(16'h0100, 16'h8100, 16'h0100, 16'h8100),
           mk(16'h0080, 16'h8080, 16'h8000, 16'h0000), vm, v, d, s, ok);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000 || s !== 1'b0) begin
      errors++;
      $display("FAIL neg_zero: valid=%b data=%h sat=%b required 1 0000 0", v, d, s);
    end
    take(v2, d2);
  endtask

  task automatic test_saturation;
    logic vm, v, s, ok, v2;
    logic [15:0] d, d2;
    do_sum(mk(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00),
           mk(16'h7F00, 16'h7F00, 16'h7F00, 16'h0000), vm, v, d, s, ok);
    checks++;
    if (v !== 1'b1 || d !== 16'h7FFF || s !== 1'b1) begin
      errors++;
      $display("FAIL sat_clamp: valid=%b data=%h sat=%b required 1 7fff 1", v, d, s);
    end
    take(v2, d2);
    do_sum('0, '0, vm, v, d, s, ok);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000 || s !== 1'b0) begin
      errors++;
      $display("FAIL sat_cleared: valid=%b data=%h sat=%b required 1 0000 0", v, d, s);
    end
    take(v2, d2);
    // Beat sums fit (0x4000, 0x6000) but their accumulation overflows.
    do_sum(mk(16'h1000, 16'h1000, 16'h1000, 16'h1000),
           mk(16'h2000, 16'h2000, 16'h2000, 16'h0000), vm, v, d, s, ok);
    checks++;
    if (d !== 16'h7FFF || s !== 1'b1) begin
      errors++;
      $display("FAIL sat_accumulate: data=%h sat=%b required 7fff 1", d, s);
    end
    take(v2, d2);
  endtask

  task automatic test_mixed;
    logic vm, v, s, ok, v2;
    logic [15:0] d, d2;
    do_sum(mk(16'h0280, 16'h80C0, 16'h8100, 16'h0040), '0, vm, v, d, s, ok);
    checks++;
    if (v !== 1'b1 || d !== 16'h0100 || s !== 1'b0) begin
      errors++;
      $display("FAIL mixed_signs: valid=%b data=%h sat=%b required 1 0100 0", v, d, s);
    end
    take(v2, d2);
    do_sum(mk(16'h8100, 16'h8100, 16'h8100, 16'h8100),
           mk(16'h8100, 16'h8100, 16'h8100, 16'h8100), vm, v, d, s, ok);
    checks++;
    if (d !== 16'h8700 || s !== 1'b0) begin
      errors++;
      $display("FAIL negative_sum: data=%h sat=%b required 8700 0", d, s);
    end
    take(v2, d2);
  endtask

  task automatic test_backpressure;
    logic vm, v, s, ok, v2;
    logic [15:0] d, d2;
    int bad;
    do_sum(mk(16'h0100, 16'h0200, 16'h0300, 16'h0400),
           mk(16'h0010, 16'h0020, 16'h0030, 16'h0040), vm, v, d, s, ok);
    checks++;
    if (v !== 1'b1 || d !== 16'h0A60 || s !== 1'b0) begin
      errors++;
      $display("FAIL hold_initial: valid=%b data=%h sat=%b required 1 0a60 0", v, d, s);
    end
    bad = 0;
    in_valid = 1'b1;
    in_data  = mk(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== 16'h0A60 || out_sat !== 1'b0 || in_ready !== 1'b0)
        bad++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d unstable cycles required 0", bad);
    end
    take(v2, d2);
    checks++;
    if (v2 !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: valid=%b in_ready=%b required 0 1", v2, in_ready);
    end
  endtask

  task automatic test_reset_abandon;
    logic ok, vm, v, s, v2;
    logic [15:0] d, d2;
    send_beat(mk(16'h0500, 16'h0500, 16'h0500, 16'h0500), ok);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abandon_state: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    do_sum(mk(16'h0100, 16'h0100, 16'h0100, 16'h0100),
           mk(16'h0100, 16'h0100, 16'h0100, 16'h0000), vm, v, d, s, ok);
    checks++;
    if (vm !== 1'b0 || v !== 1'b1 || d !== 16'h0700 || s !== 1'b0) begin
      errors++;
      $display("FAIL abandon_next: mid=%b valid=%b data=%h sat=%b required 0 1 0700 0", vm, v, d, s);
    end
    // Reset while a result is pending drops it.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
      errors++;
      $display("FAIL abandon_out: valid=%b data=%h required 0 0000", out_valid, out_data);
    end
    v2 = 1'b0; d2 = '0;
  endtask

  task automatic test_back_to_back;
    logic vm, v, s, ok, v2;
    logic [15:0] d, d2;
    do_sum(mk(16'h0001, 16'h0002, 16'h0003, 16'h0004),
           mk(16'h0005, 16'h0006, 16'h0007, 16'h0008), vm, v, d, s, ok);
    take(v2, d2);
    checks++;
    if (d !== 16'h001C || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: data=%h in_ready=%b required 001c 1", d, in_ready);
    end
    do_sum(mk(16'h8001, 16'h0003, 16'h0000, 16'h0000), '0, vm, v, d, s, ok);
    checks++;
    if (ok !== 1'b1 || v !== 1'b1 || d !== 16'h0002) begin
      errors++;
      $display("FAIL b2b_second: ok=%b valid=%b data=%h required 1 1 0002", ok, v, d);
    end
    take(v2, d2);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_neg_zero();
    test_saturation();
    test_mixed();
    test_backpressure();
    test_reset_abandon();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
